fetch: RTL and testbench

//  Instruction fetch stage of the Beta pipeline; producer of inst/pc_plus_four consumed by decode.

---
 rtl/fetch.sv | 136 +++++++++++++
 tb/tb_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Beta pipeline instruction fetch stage. It owns the PC and keeps at most one instruction-memory request outstanding.
// It handles redirects and exceptions, and inserts NOP bubbles when no instruction is ready.
`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif

module fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0004,
    parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        op_jmp,
    input  logic        op_beq,
    input  logic        op_bne,
    input  logic        zero,
    input  logic [31:0] jump_addr,
    input  logic [31:0] branch_addr,
    input  logic        except_illop,
    input  logic        except_irq,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc_plus_four
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_ppf;
    logic [31:0] r_hold;
    logic        r_squash;

    logic        w_branch;
    logic        w_redirect;
    logic        w_irq;
    logic        w_flush;
    logic [31:0] w_target;
    logic        w_deliver;
    logic [31:0] w_word;

    assign w_branch   = (op_beq & zero) | (op_bne & ~zero);
    assign w_redirect = ~stall & (op_jmp | w_branch);
    // Interrupts are masked while the PC is in supervisor space.
    assign w_irq      = except_irq & ~r_pc[31];
    assign w_flush    = except_illop | w_irq | w_redirect;

    always_comb begin
        w_target = {r_pc[31] & jump_addr[31], jump_addr[30:2], 2'b00};
        if (except_illop)
            w_target = ILLOP_VECTOR;
        else if (w_irq)
            w_target = IRQ_VECTOR;
        else if (w_branch)
            w_target = branch_addr;
    end

    always_comb begin
        w_deliver = 1'b0;
        w_word    = imem_rdata;
        if (r_state == S_WAIT && imem_rvalid && !r_squash && !stall && !w_flush) begin
            w_deliver = 1'b1;
        end else if (r_state == S_HOLD && !stall && !w_flush) begin
            w_deliver = 1'b1;
            w_word    = r_hold;
        end
    end

    assign imem_req     = (r_state == S_REQ);
    assign imem_addr    = r_pc;
    assign inst         = r_inst;
    assign pc_plus_four = r_ppf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_VECTOR;
            r_inst   <= `INST_NOP;
            r_ppf    <= RESET_VECTOR;
            r_hold   <= '0;
            r_squash <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    // A redirect that coincides with a grant leaves a stale response in flight.
                    if (imem_gnt) begin
                        r_state  <= S_WAIT;
                        r_squash <= w_flush;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_squash <= 1'b0;
                        if (r_squash || w_flush) begin
                            r_state <= S_REQ;
                        end else if (stall) begin
                            r_hold  <= imem_rdata;
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end else if (w_flush) begin
                        r_squash <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_flush || !stall)
                        r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase

            if (w_flush)
                r_pc <= w_target;
            else if (w_deliver)
                r_pc <= r_pc + 32'd4;

            if (!stall) begin
                if (w_deliver) begin
                    r_inst <= w_word;
                    r_ppf  <= r_pc + 32'd4;
                end else begin
                    r_inst <= `INST_NOP;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed testbench for the fetch stage. It plays the instruction memory by hand
// and checks every output against hand-computed values.
`timescale 1ns/1ps

module tb_fetch;

    localparam logic [31:0] NOP = 32'h83FF_F800;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        op_jmp;
    logic        op_beq;
    logic        op_bne;
    logic        zero;
    logic [31:0] jump_addr;
    logic [31:0] branch_addr;
    logic        except_illop;
    logic        except_irq;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc_plus_four;

    int errorCount = 0;
    int checkCount = 0;

    fetch dut (
        .clk(clk), .rst(rst), .stall(stall),
        .op_jmp(op_jmp), .op_beq(op_beq), .op_bne(op_bne), .zero(zero),
        .jump_addr(jump_addr), .branch_addr(branch_addr),
        .except_illop(except_illop), .except_irq(except_irq),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .pc_plus_four(pc_plus_four)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1ns past the edge so outputs are sampled away from it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        stall = 0; op_jmp = 0; op_beq = 0; op_bne = 0; zero = 0;
        jump_addr = 0; branch_addr = 0; except_illop = 0; except_irq = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        #12;
        checkOutput("reset inst", inst, NOP);
        checkOutput("reset ppf", pc_plus_four, 32'h8000_0000);
        checkOutput("reset req", {31'b0, imem_req}, 1);
        checkOutput("reset addr", imem_addr, 32'h8000_0000);
        applyStimulus();
        rst = 0;

        // Basic fetch: grant and respond immediately.
        imem_gnt = 1;
        applyStimulus();
        imem_gnt = 0;
        checkOutput("wait req low", {31'b0, imem_req}, 0);
        checkOutput("wait inst nop", inst, NOP);
        imem_rvalid = 1; imem_rdata = 32'h1111_1111;
        applyStimulus();
        imem_rvalid = 0;
        checkOutput("first inst", inst, 32'h1111_1111);
        checkOutput("first ppf", pc_plus_four, 32'h8000_0004);
        checkOutput("second addr", imem_addr, 32'h8000_0004);
        checkOutput("second req", {31'b0, imem_req}, 1);
        imem_gnt = 1;
        applyStimulus();
        imem_gnt = 0;
        checkOutput("bubble inst", inst, NOP);
        checkOutput("bubble ppf", pc_plus_four, 32'h8000_0004);

        // Response arrives during a three-cycle stall.
        stall = 1; imem_rvalid = 1; imem_rdata = 32'h2222_2222;
        applyStimulus();
        imem_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall inst", inst, NOP);
            checkOutput("stall ppf", pc_plus_four, 32'h8000_0004);
            checkOutput("stall req", {31'b0, imem_req}, 0);
            if (i < 2) applyStimulus();
        end
        stall = 0;
        applyStimulus();
        checkOutput("held inst", inst, 32'h2222_2222);
        checkOutput("held ppf", pc_plus_four, 32'h8000_0008);
        checkOutput("after hold addr", imem_addr, 32'h8000_0008);
        applyStimulus();
        checkOutput("no duplicate", inst, NOP);

        // BEQ taken while a request is outstanding.
        imem_gnt = 1;
        applyStimulus();
        imem_gnt = 0;
        op_beq = 1; zero = 1; branch_addr = 32'h8000_0100;
        applyStimulus();
        op_beq = 0; zero = 0;
        checkOutput("beq req low", {31'b0, imem_req}, 0);
        imem_rvalid = 1; imem_rdata = 32'h3333_3333;
        applyStimulus();
        imem_rvalid = 0;
        checkOutput("stale dropped", inst, NOP);
        checkOutput("stale ppf", pc_plus_four, 32'h8000_0008);
        checkOutput("beq addr", imem_addr, 32'h8000_0100);
        imem_gnt = 1;
        applyStimulus();
        imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h4444_4444;
        applyStimulus();
        imem_rvalid = 0;
        checkOutput("target inst", inst, 32'h4444_4444);
        checkOutput("target ppf", pc_plus_four, 32'h8000_0104);

        // JMP from supervisor keeps bit 31 and masks the low bits.
        op_jmp = 1; jump_addr = 32'h8000_0203;
        applyStimulus();
        op_jmp = 0;
        checkOutput("jmp sup addr", imem_addr, 32'h8000_0200);
        checkOutput("jmp annul", inst, NOP);

        // An IRQ taken in supervisor mode is ignored.
        except_irq = 1; imem_gnt = 1;
        applyStimulus();
        imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h5555_5555;
        applyStimulus();
        imem_rvalid = 0; except_irq = 0;
        checkOutput("irq masked inst", inst, 32'h5555_5555);
        checkOutput("irq masked ppf", pc_plus_four, 32'h8000_0204);

        // Drop into user space, then JMP to an address with bit 31 set.
        op_jmp = 1; jump_addr = 32'h0000_0043;
        applyStimulus();
        checkOutput("jmp user addr", imem_addr, 32'h0000_0040);
        jump_addr = 32'h8000_0200;
        applyStimulus();
        op_jmp = 0;
        checkOutput("jmp no sup", imem_addr, 32'h0000_0200);

        // A redirect in the same cycle as rvalid annuls the word.
        imem_gnt = 1;
        applyStimulus();
        imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h6666_6666; op_jmp = 1; jump_addr = 32'h0000_0300;
        applyStimulus();
        imem_rvalid = 0; op_jmp = 0;
        checkOutput("annul inst", inst, NOP);
        checkOutput("annul ppf", pc_plus_four, 32'h8000_0204);
        checkOutput("annul addr", imem_addr, 32'h0000_0300);

        // IRQ from user mode.
        except_irq = 1;
        applyStimulus();
        except_irq = 0;
        checkOutput("irq vector", imem_addr, 32'h8000_0008);

        // illop and irq together from user mode.
        op_jmp = 1; jump_addr = 32'h0000_0400;
        applyStimulus();
        op_jmp = 0;
        checkOutput("user 400", imem_addr, 32'h0000_0400);
        except_illop = 1; except_irq = 1; op_beq = 1; zero = 1; branch_addr = 32'h0000_0500;
        applyStimulus();
        except_illop = 0; except_irq = 0; op_beq = 0; zero = 0;
        checkOutput("illop priority", imem_addr, 32'h8000_0004);

        // Reset in S_WAIT with a late response afterwards.
        imem_gnt = 1;
        applyStimulus();
        imem_gnt = 0;
        rst = 1;
        #2;
        checkOutput("async rst addr", imem_addr, 32'h8000_0000);
        checkOutput("async rst req", {31'b0, imem_req}, 1);
        applyStimulus();
        rst = 0;
        imem_rvalid = 1; imem_rdata = 32'h7777_7777;
        applyStimulus();
        imem_rvalid = 0;
        checkOutput("late rvalid inst", inst, NOP);
        checkOutput("late rvalid addr", imem_addr, 32'h8000_0000);
        checkOutput("late rvalid req", {31'b0, imem_req}, 1);
        imem_gnt = 1;
        applyStimulus();
        imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h8888_8888;
        applyStimulus();
        imem_rvalid = 0;
        checkOutput("restart inst", inst, 32'h8888_8888);
        checkOutput("restart ppf", pc_plus_four, 32'h8000_0004);

        // PC wraps from the top of the address space.
        op_jmp = 1; jump_addr = 32'hFFFF_FFFC;
        applyStimulus();
        op_jmp = 0;
        checkOutput("top addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1;
        applyStimulus();
        imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h9999_9999;
        applyStimulus();
        imem_rvalid = 0;
        checkOutput("wrap inst", inst, 32'h9999_9999);
        checkOutput("wrap ppf", pc_plus_four, 32'h0000_0000);
        checkOutput("wrap addr", imem_addr, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
